gray_cntr_monitor: RTL

Receive-side companion to the Gray code counter. Samples a Gray-coded count bus on enable, decodes it to binary through a two-stage pipeline and reports the number of counter steps since the previous sample. Flags any sample-to-sample transition that changes more than one bit as a coding error. Sits at the consumer end of a Gray-coded pointer, for example a FIFO pointer already synchronized into this clock domain.

---
 rtl/gray_cntr_monitor_pkg.sv | 28 ++
 rtl/gray_cntr_monitor_gray_to_bin.sv | 20 ++
 rtl/gray_cntr_monitor.sv | 87 ++++++++
 3 files changed

// File: rtl/gray_cntr_monitor_pkg.sv
// Shared helpers for the Gray-count monitor: a width-generic Gray decode,
// a multi-bit-change test and the default reset value.
package gray_cntr_monitor_pkg;

    localparam int unsigned MaxWidth = 64;

    localparam logic [MaxWidth-1:0] DefaultInit = '0;

    // Zero-extended inputs decode correctly at any width <= MaxWidth, since the
    // running XOR of the upper zero bits stays zero.
    function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
        logic [MaxWidth-1:0] b;
        logic                acc;
        acc = 1'b0;
        b   = '0;
        for (int i = int'(MaxWidth) - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    // True when more than one bit is set (clearing the lowest set bit leaves a residue).
    function automatic logic hamming_gt1(input logic [MaxWidth-1:0] d);
        return (d & (d - MaxWidth'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_cntr_monitor_gray_to_bin.sv
// Combinational Gray-to-binary decoder.
module gray_to_bin #(
    parameter int unsigned width = 2
) (
    input  logic [width-1:0] g,
    output logic [width-1:0] b
);

    logic acc;

    always_comb begin
        acc = 1'b0;
        b   = '0;
        for (int i = int'(width) - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
    end

endmodule

// File: rtl/gray_cntr_monitor.sv
// Samples a Gray-coded count, decodes it over two registered stages and reports
// the step count since the previous sample plus a sticky multi-bit-change error.
module gray_cntr_monitor
    import gray_cntr_monitor_pkg::*;
#(
    parameter int unsigned      width = 2,
    parameter logic [width-1:0] init  = DefaultInit[width-1:0]
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [width-1:0] G_IN,
    input  logic             CLR_ERR,
    output logic [width-1:0] B_OUT,
    output logic [width-1:0] DELTA,
    output logic             CHG,
    output logic             ERR
);

    if (width < 2 || width > MaxWidth) begin : g_width_check
        $error("gray_cntr_monitor: width must be in 2..%0d", MaxWidth);
    end

    localparam logic [width-1:0] InitBin = width'(gray2bin(MaxWidth'(init)));

    logic             v1_q;
    logic [width-1:0] g1_q;
    logic [width-1:0] g_prev_q;
    logic [width-1:0] b_prev_q;
    logic [width-1:0] b_out_q;
    logic [width-1:0] delta_q;
    logic             chg_q;
    logic             err_q;
    logic [width-1:0] b_new;
    logic             multi_bit;

    gray_to_bin #(
        .width (width)
    ) u_gray_to_bin (
        .g (g1_q),
        .b (b_new)
    );

    assign multi_bit = hamming_gt1(MaxWidth'(g1_q ^ g_prev_q));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            v1_q     <= 1'b0;
            g1_q     <= init;
            g_prev_q <= init;
            b_prev_q <= InitBin;
            b_out_q  <= InitBin;
            delta_q  <= '0;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            v1_q <= EN;
            if (EN) begin
                g1_q <= G_IN;
            end

            if (v1_q) begin
                delta_q  <= b_new - b_prev_q;
                chg_q    <= (g1_q != g_prev_q);
                b_out_q  <= b_new;
                g_prev_q <= g1_q;
                b_prev_q <= b_new;
            end else begin
                delta_q <= '0;
                chg_q   <= 1'b0;
            end

            // A fresh error outranks a clear request in the same cycle.
            if (v1_q && multi_bit) begin
                err_q <= 1'b1;
            end else if (CLR_ERR) begin
                err_q <= 1'b0;
            end
        end
    end

    assign B_OUT = b_out_q;
    assign DELTA = delta_q;
    assign CHG   = chg_q;
    assign ERR   = err_q;

endmodule
